// File: rtl/vernam_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : vernam_decoder_if
// Description : Signal bundle for the Vernam decoder. Carries the command
//               (start/base_addr/length), status (busy/done/byte_count),
//               the ciphertext RAM read port, the key-stream handshake and
//               the plaintext output handshake.
//   slave  : decoder side (drives status, RAM address, key_ready, plaintext)
//   master : environment side (drives command, RAM data, key, pt_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface vernam_decoder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] key_data;
  logic                  key_valid;
  logic                  key_ready;
  logic [DATA_WIDTH-1:0] pt_data;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [ADDR_WIDTH:0]   byte_count;

  modport slave (
    input  start, base_addr, length, ram_dout, key_data, key_valid, pt_ready,
    output busy, done, ram_en, ram_addr, key_ready, pt_data, pt_valid, byte_count
  );

  modport master (
    output start, base_addr, length, ram_dout, key_data, key_valid, pt_ready,
    input  busy, done, ram_en, ram_addr, key_ready, pt_data, pt_valid, byte_count
  );
endinterface
`default_nettype wire

// File: rtl/vernam_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vernam_decoder
// Description : Reads a run of ciphertext bytes from block RAM, XORs each one
//               with one key-stream byte and emits the plaintext on a
//               valid/ready stream. One byte is fully handled (fetch, RAM
//               wait, key handshake, output handshake) before the next.
// Ports       :
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - vernam_decoder_if.slave: command, status, RAM read port,
//           key stream in, plaintext stream out
// Revision    : 1.0 - initial release
// ============================================================================
module vernam_decoder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int RAM_LATENCY = 1   // 1..3
) (
  input  logic                 clk,
  input  logic                 reset,
  vernam_decoder_if.slave      bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_KEY   = 3'd3;
  localparam logic [2:0] c_OUT   = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  localparam logic [1:0]          c_LAT_LAST = 2'(RAM_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] c_REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_REM_ZERO = '0;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [1:0]            r_lat_cnt;
  logic [DATA_WIDTH-1:0] r_cipher;
  logic [DATA_WIDTH-1:0] r_pt_data;
  logic                  r_pt_valid;
  logic [ADDR_WIDTH:0]   r_byte_count;

  // Status and strobes are pure state decodes so no input reaches them combinationally.
  assign bus.busy       = (r_state != c_IDLE);
  assign bus.done       = (r_state == c_DONE);
  assign bus.ram_en     = (r_state == c_FETCH);
  assign bus.key_ready  = (r_state == c_KEY);
  assign bus.ram_addr   = r_addr;
  assign bus.pt_data    = r_pt_data;
  assign bus.pt_valid   = r_pt_valid;
  assign bus.byte_count = r_byte_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_lat_cnt    <= '0;
      r_cipher     <= '0;
      r_pt_data    <= '0;
      r_pt_valid   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_addr       <= bus.base_addr;
            r_remaining  <= bus.length;
            r_byte_count <= '0;
            r_state      <= (bus.length == c_REM_ZERO) ? c_DONE : c_FETCH;
          end
        end

        c_FETCH: begin
          r_lat_cnt <= '0;
          r_state   <= c_WAIT;
        end

        c_WAIT: begin
          if (r_lat_cnt == c_LAT_LAST) begin
            r_cipher <= bus.ram_dout;
            r_state  <= c_KEY;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end

        c_KEY: begin
          // key_ready is high throughout this state, so key_valid alone completes the handshake.
          if (bus.key_valid) begin
            r_pt_data  <= r_cipher ^ bus.key_data;
            r_pt_valid <= 1'b1;
            r_state    <= c_OUT;
          end
        end

        c_OUT: begin
          if (bus.pt_ready) begin
            r_pt_valid   <= 1'b0;
            r_byte_count <= r_byte_count + (ADDR_WIDTH+1)'(1);
            r_addr       <= r_addr + ADDR_WIDTH'(1);
            r_remaining  <= r_remaining - (ADDR_WIDTH+1)'(1);
            // Exit on the last byte rather than at zero so the counter never wraps.
            r_state      <= (r_remaining == c_REM_ONE) ? c_DONE : c_FETCH;
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vernam_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vernam_decoder
// Description : Scoreboard bench for vernam_decoder. Expected plaintext is
//               pushed as mem[base+i] ^ key[i] when a run is planned; a
//               monitor pops and compares on each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vernam_decoder;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 1;
  localparam int PER = 3 + LAT;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vernam_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vernam_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // Ciphertext RAM: read data appears LAT cycles after ram_en.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [LAT];
  initial forever begin
    @(posedge clk);
    if (bus.ram_en) rd_pipe[0] <= mem[bus.ram_addr];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.ram_dout = rd_pipe[LAT-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] key_q [$];
  logic [7:0] exp_q [$];
  int  key_mode = 0;   // 0: key offered whenever queued, 1: random, 2: withheld
  int  pt_mode  = 0;   // 0: sink always ready, 1: random, 2: stalled
  bit  key_pend = 0;

  int ram_en_cnt, key_hs_cnt, pt_hs_cnt, done_cnt, kr_cnt;
  int start_cyc, last_hs_cyc, done_cyc;
  int hs_cyc [$];
  logic [7:0] addr_log [$];
  bit hold_prev = 0;
  logic [7:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, between active edges.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      if (hold_prev) begin
        check("pt_valid_held", {31'd0, bus.pt_valid}, 1);
        check("pt_data_held", {24'd0, bus.pt_data}, {24'd0, hold_data});
      end
      hold_prev = bus.pt_valid && !bus.pt_ready;
      hold_data = bus.pt_data;
      if (bus.start && !bus.busy) start_cyc = cyc;
      if (bus.ram_en) begin
        ram_en_cnt++;
        addr_log.push_back(bus.ram_addr);
      end
      if (bus.key_ready) kr_cnt++;
      if (bus.key_valid && bus.key_ready) begin
        key_hs_cnt++;
        key_pend = 1;
      end
      if (bus.pt_valid && bus.pt_ready) begin
        pt_hs_cnt++;
        last_hs_cyc = cyc;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pt_extra: got 0x%0h, want no output", bus.pt_data);
        end else begin
          check("pt_data", {24'd0, bus.pt_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_pend) begin
      if (key_q.size() > 0) void'(key_q.pop_front());
      key_pend = 0;
    end
    bus.key_valid = (key_q.size() > 0) &&
                    ((key_mode == 0) || ((key_mode == 1) && ($urandom_range(1, 0) == 1)));
    bus.key_data  = (key_q.size() > 0) ? key_q[0] : 8'($urandom);
    bus.pt_ready  = (pt_mode == 0) ? 1'b1 :
                    (pt_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
  endtask

  task automatic clear_stats();
    ram_en_cnt = 0; key_hs_cnt = 0; pt_hs_cnt = 0; done_cnt = 0; kr_cnt = 0;
    hs_cyc.delete();
    addr_log.delete();
  endtask

  task automatic plan_random(input logic [7:0] base, input int len);
    logic [7:0] k;
    for (int i = 0; i < len; i++) begin
      k = 8'($urandom);
      key_q.push_back(k);
      exp_q.push_back(mem[8'(base + i)] ^ k);
    end
  endtask

  task automatic launch(input logic [7:0] base, input int len);
    clear_stats();
    bus.base_addr = base;
    bus.length    = 9'(len);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic finish_run(input string name, input int len);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_busy_after"}, {31'd0, bus.busy}, 0);
    check({name, "_byte_count"}, {23'd0, bus.byte_count}, len);
    check({name, "_ram_reads"}, ram_en_cnt, len);
    check({name, "_key_takes"}, key_hs_cnt, len);
    check({name, "_outputs"}, pt_hs_cnt, len);
    check({name, "_keys_left"}, key_q.size(), 0);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_done_time"}, done_cyc, ((len == 0) ? start_cyc : last_hs_cyc) + 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},      {31'd0, bus.busy}, 0);
    check({name, "_done"},      {31'd0, bus.done}, 0);
    check({name, "_ram_en"},    {31'd0, bus.ram_en}, 0);
    check({name, "_key_ready"}, {31'd0, bus.key_ready}, 0);
    check({name, "_pt_valid"},  {31'd0, bus.pt_valid}, 0);
    check({name, "_ram_addr"},  {24'd0, bus.ram_addr}, 0);
    check({name, "_pt_data"},   {24'd0, bus.pt_data}, 0);
    check({name, "_byte_count"},{23'd0, bus.byte_count}, 0);
  endtask

  initial begin
    int n, seen;
    logic [7:0] d;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
    bus.key_valid = 1'b0; bus.key_data = '0; bus.pt_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);

    #12;
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // Single byte
    mem[8'h10] = 8'hA5;
    key_q.push_back(8'h3C);
    exp_q.push_back(8'h99);
    launch(8'h10, 1);
    finish_run("single", 1);
    if (addr_log.size() > 0) check("single_addr", {24'd0, addr_log[0]}, 32'h10);

    // Stream of four, key and sink always ready
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55; mem[3] = 8'h12;
    key_q.push_back(8'h11); key_q.push_back(8'h0F); key_q.push_back(8'h55); key_q.push_back(8'hFF);
    exp_q.push_back(8'h11); exp_q.push_back(8'hF0); exp_q.push_back(8'h00); exp_q.push_back(8'hED);
    launch(8'h00, 4);
    finish_run("stream4", 4);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("stream4_spacing", hs_cyc[i] - hs_cyc[i-1], PER);

    // Address wrap
    plan_random(8'hFE, 3);
    launch(8'hFE, 3);
    finish_run("wrap", 3);
    check("wrap_reads", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("wrap_addr0", {24'd0, addr_log[0]}, 32'hFE);
      check("wrap_addr1", {24'd0, addr_log[1]}, 32'hFF);
      check("wrap_addr2", {24'd0, addr_log[2]}, 32'h00);
    end

    // Key starvation then output backpressure
    plan_random(8'h40, 2);
    key_mode = 2;
    launch(8'h40, 2);
    n = 0;
    while (!bus.key_ready && n < 50) begin tick(); n++; end
    check("bp_key_ready_seen", {31'd0, bus.key_ready}, 1);
    repeat (5) begin
      tick();
      check("bp_key_ready_starved", {31'd0, bus.key_ready}, 1);
      check("bp_no_key_taken", key_hs_cnt, 0);
    end
    key_mode = 0;
    pt_mode  = 2;
    n = 0;
    while (!bus.pt_valid && n < 50) begin tick(); n++; end
    check("bp_pt_valid_seen", {31'd0, bus.pt_valid}, 1);
    d = bus.pt_data;
    repeat (7) begin
      tick();
      check("bp_pt_valid_stable", {31'd0, bus.pt_valid}, 1);
      check("bp_pt_data_stable", {24'd0, bus.pt_data}, {24'd0, d});
      check("bp_one_key", key_hs_cnt, 1);
    end
    pt_mode = 0;
    finish_run("bp", 2);

    // Zero length
    launch(8'h20, 0);
    finish_run("zero", 0);
    check("zero_key_ready", kr_cnt, 0);

    // start while busy is ignored
    plan_random(8'h80, 3);
    launch(8'h80, 3);
    repeat (3) tick();
    bus.base_addr = 8'h00;
    bus.length    = 9'd7;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    finish_run("busy_start", 3);

    // Reset during the RAM wait of byte 2 of 4
    plan_random(8'h30, 4);
    launch(8'h30, 4);
    seen = 0;
    n = 0;
    while (n < 200) begin
      if (bus.ram_en) begin
        seen++;
        if (seen == 2) break;
      end
      tick();
      n++;
    end
    check("rst_second_fetch", seen, 2);
    tick();
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    #20;
    check("rst_no_done", done_cnt, 0);
    key_q.delete();
    exp_q.delete();
    key_pend = 0;
    reset = 1'b1;
    tick();
    plan_random(8'h30, 4);
    launch(8'h30, 4);
    finish_run("after_rst", 4);

    // Randomized runs with random key gaps and sink stalls
    key_mode = 1;
    pt_mode  = 1;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] b;
      int len;
      b   = 8'($urandom);
      len = $urandom_range(24, 0);
      plan_random(b, len);
      launch(b, len);
      finish_run("rand", len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vernam_decoder.md
# vernam_decoder

Hardware decryption end of the Vernam one-time-pad datapath. Once the ciphertext has been stored in block RAM by the encrypting PicoBlaze, this block reads a run of ciphertext bytes from that RAM and consumes one key byte per ciphertext byte from the key-stream source, which is the same generator that fed the encryptor. It emits plaintext as `ciphertext XOR key` on a valid/ready stream. Each byte is fetched, keyed and handed off in turn; a single FSM sequences the work.

## Interface
- `ADDR_WIDTH`, 8, RAM address width; addresses wrap modulo 2^ADDR_WIDTH
- `DATA_WIDTH`, 8, width of ciphertext, key and plaintext bytes
- `RAM_LATENCY`, 1, cycles from `ram_en` high to valid `ram_dout` (range 1..3)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first ciphertext address, latched on `start`
- `length`  in  ADDR_WIDTH+1  byte count, latched on `start`; 0 is legal
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a run completes
- `ram_en`  out  1  RAM read enable, one cycle per byte
- `ram_addr`  out  ADDR_WIDTH  RAM read address
- `ram_dout`  in  DATA_WIDTH  RAM read data
- `key_data`  in  DATA_WIDTH  key byte
- `key_valid`  in  1  key byte available
- `key_ready`  out  1  decoder accepts the key byte this cycle
- `pt_data`  out  DATA_WIDTH  plaintext byte
- `pt_valid`  out  1  plaintext byte available
- `pt_ready`  in  1  sink accepts the plaintext byte
- `byte_count`  out  ADDR_WIDTH+1  bytes delivered in the current or last run

## Operation
- States: IDLE, FETCH, WAIT, KEY, OUT, DONE.
- IDLE:
  - `start`=1 latches `base_addr` into the address register and `length` into the remaining counter.
  - `byte_count` is cleared.
  - If `length`==0, go to DONE; otherwise go to FETCH.
- FETCH: `ram_en`=1 and `ram_addr`=the address register for exactly one cycle; then go to WAIT.
- WAIT:
  - Held for RAM_LATENCY cycles, counted by a latency counter.
  - On the last cycle, `ram_dout` is captured into the ciphertext register; then go to KEY.
- KEY:
  - `key_ready`=1; this is the only state where it is high.
  - On `key_valid & key_ready`: `pt_data` <= ciphertext register XOR `key_data`, `pt_valid` <= 1, go to OUT.
  - Each key byte is consumed exactly once; no key byte is taken without a matching ciphertext byte.
- OUT:
  - `pt_data` and `pt_valid` are held while `pt_ready`=0.
  - On `pt_ready`: `pt_valid` <= 0, `byte_count` +1, address +1 (mod 2^ADDR_WIDTH), remaining −1.
  - If remaining was 1, go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE. `byte_count` holds until the next accepted `start`.
- `start` while `busy`=1 is ignored; no queuing.
- Arithmetic:
  - Unsigned throughout.
  - The address wraps from 2^ADDR_WIDTH−1 to 0 mid-run.
  - The remaining counter never underflows; the exit is on remaining==1 at hand-off.
- Asynchronous reset assertion at any point aborts a run immediately:
  - The partially consumed key byte is lost.
  - No `done` is issued.
  - The FSM returns to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `ram_en`, `key_ready`, `pt_valid` = 0.
  - `ram_addr`, `pt_data`, `byte_count` = 0.
- All outputs are registered or decoded from state only.
- No combinational path from `key_valid` or `pt_ready` to any output.
- Timing from `start` accepted at edge T:
  - FETCH during T+1: `ram_en` high.
  - Ciphertext captured at edge T+1+RAM_LATENCY.
  - KEY from T+2+RAM_LATENCY.
- Per byte with key and sink always ready: 3+RAM_LATENCY cycles (4 at default).
- `done` rises the cycle after the last `pt_valid & pt_ready` handshake.
- `length`=0: `done` pulses in the cycle after `start`, with no RAM or key traffic.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.

## Test plan
- Single byte:
  - Stimulus: RAM[0x10]=0xA5, key 0x3C, `length`=1, `base_addr`=0x10.
  - Response: `pt_data`=0x99; one `ram_en`; one key handshake; `done` one cycle after hand-off; `byte_count`=1.
- Stream of 4, sink and key always ready:
  - Stimulus: RAM[0..3]=0x00,0xFF,0x55,0x12; keys 0x11,0x0F,0x55,0xFF.
  - Response: outputs 0x11,0xF0,0x00,0xED at a 4-cycle spacing.
- Address wrap:
  - Stimulus: `base_addr`=0xFE, `length`=3.
  - Response: `ram_addr` sequence 0xFE,0xFF,0x00; `byte_count`=3.
- Backpressure and starvation:
  - Stimulus: `key_valid` low for 5 cycles in KEY, then `pt_ready` low for 7 cycles in OUT.
  - Response: `key_ready` stays high throughout the starvation; `pt_data`/`pt_valid` stable while `pt_ready` is low; no extra key is consumed.
- Zero length and busy `start`:
  - Stimulus: `length`=0.
  - Response: `done` the next cycle; no `ram_en`, no `key_ready`.
  - Stimulus: `start` pulsed mid-run.
  - Response: ignored; the run completes with the original `length`.
- Reset mid-run:
  - Stimulus: assert `reset` low in WAIT of byte 2 of 4.
  - Response: all outputs go to reset values asynchronously; no `done`; a fresh `start` runs cleanly.
